gate_sequencer: RTL

- Parametrised timebase and gate controller for the frequency meter.
- Replaces the fixed 2 s gate and 1 s reset dividers with a single sequencer.
- Each cycle: clear pulse to the counters, then a gate of selectable length, then a latch strobe, then an idle gap.
- Runs single-shot or continuous, with abort; drives the counter and display-latch logic directly.

---
 rtl/gate_seq_pkg.sv | 30 +++
 rtl/ms_prescaler.sv | 34 +++
 rtl/gate_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the frequency-meter gate sequencer.
package gate_seq_pkg;

  localparam int GATE_SEL_W = 2;

  // Gate lengths in milliseconds, indexed by gate_sel.
  localparam int unsigned GATE_MS_0 = 10;
  localparam int unsigned GATE_MS_1 = 100;
  localparam int unsigned GATE_MS_2 = 1000;
  localparam int unsigned GATE_MS_3 = 10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GATE,
    ST_LATCH,
    ST_GAP
  } state_t;

  // Gate length in ms for a selector value.
  function automatic int unsigned gate_ms(input logic [GATE_SEL_W-1:0] sel);
    case (sel)
      2'd0:    gate_ms = GATE_MS_0;
      2'd1:    gate_ms = GATE_MS_1;
      2'd2:    gate_ms = GATE_MS_2;
      default: gate_ms = GATE_MS_3;
    endcase
  endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Divides clk50 down to a one-cycle millisecond tick.
module ms_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count 0..TICK_DIV-1 while enabled; the clear wins over counting.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_tick = i_en && !i_clr && (r_cnt == CNT_LAST);

endmodule

// File: rtl/gate_sequencer.sv
// Clear / gate / latch / gap sequencer for the frequency meter.
// Outputs are registered and set on the same edge as the state change.
module gate_sequencer
  import gate_seq_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int CLR_CYC  = 10,
  parameter int GAP_CYC  = 16,
  parameter int MS_W     = 14
) (
  input  logic                  clk50,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  abort,
  input  logic [GATE_SEL_W-1:0] gate_sel,
  output logic                  gate,
  output logic                  clr_n,
  output logic                  latch,
  output logic                  busy,
  output logic [GATE_SEL_W-1:0] cur_sel
);

  // One phase counter serves both CLEAR and GAP.
  localparam int PH_MAX = (CLR_CYC > GAP_CYC) ? CLR_CYC : GAP_CYC;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] CLR_LAST = PH_W'(CLR_CYC - 1);
  localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_CYC - 1);

  state_t                  r_state;
  logic [PH_W-1:0]         r_phase;
  logic [MS_W-1:0]         r_ms;
  logic                    r_gate;
  logic                    r_clr_n;
  logic                    r_latch;
  logic                    r_busy;
  logic [GATE_SEL_W-1:0]   r_cur_sel;

  logic                    w_pre_clr;
  logic                    w_pre_en;
  logic                    w_tick;
  logic [MS_W-1:0]         w_ms_last;

  // Prescaler only runs inside GATE, so it always starts from zero on entry.
  assign w_pre_en  = (r_state == ST_GATE);
  assign w_pre_clr = !w_pre_en;
  assign w_ms_last = MS_W'(gate_ms(r_cur_sel) - 1);

  ms_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk50  (clk50),
    .rst_n  (rst_n),
    .i_clr  (w_pre_clr),
    .i_en   (w_pre_en),
    .o_tick (w_tick)
  );

  // Sequencer FSM with its phase and ms counters and registered outputs.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_ms      <= '0;
      r_gate    <= 1'b0;
      r_clr_n   <= 1'b1;
      r_latch   <= 1'b0;
      r_busy    <= 1'b0;
      r_cur_sel <= '0;
    end else if (abort) begin
      // Abort drops straight to IDLE; the aborted gate gets no latch strobe.
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_ms    <= '0;
      r_gate  <= 1'b0;
      r_clr_n <= 1'b1;
      r_latch <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_CLEAR;
            r_phase   <= '0;
            r_clr_n   <= 1'b0;
            r_busy    <= 1'b1;
            r_cur_sel <= gate_sel;
          end
        end
        ST_CLEAR: begin
          if (r_phase == CLR_LAST) begin
            r_state <= ST_GATE;
            r_phase <= '0;
            r_ms    <= '0;
            r_clr_n <= 1'b1;
            r_gate  <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        ST_GATE: begin
          if (w_tick) begin
            if (r_ms == w_ms_last) begin
              r_state <= ST_LATCH;
              r_ms    <= '0;
              r_gate  <= 1'b0;
              r_latch <= 1'b1;
            end else begin
              r_ms <= r_ms + 1'b1;
            end
          end
        end
        ST_LATCH: begin
          r_state <= ST_GAP;
          r_phase <= '0;
          r_latch <= 1'b0;
        end
        ST_GAP: begin
          if (r_phase == GAP_LAST) begin
            r_phase <= '0;
            if (cont) begin
              r_state   <= ST_CLEAR;
              r_clr_n   <= 1'b0;
              r_cur_sel <= gate_sel;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_phase <= '0;
          r_ms    <= '0;
          r_gate  <= 1'b0;
          r_clr_n <= 1'b1;
          r_latch <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gate    = r_gate;
  assign clr_n   = r_clr_n;
  assign latch   = r_latch;
  assign busy    = r_busy;
  assign cur_sel = r_cur_sel;

endmodule
